fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Frames a raw real-valued sample stream into FFT-core input packets.
//  Sits between the ADC sample source and the FFT core sink port.
//  Latches transform length and direction per frame, drives sink_sop/eop/valid
//  with backpressure, and reports frame progress to the host.
// PARAMETERS
//  DATA_W   14   sample width (real and imag)
//  PTS_W    11   width of fft_pts / cfg_pts (max 1024 points)
//  CNT_W    16   width of frame_cnt
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       request one frame (level sampled in IDLE)
//  abort        in   1       terminate current frame
//  cfg_pts      in   PTS_W   transform length: 64,128,256,512 or 1024
//  cfg_inverse  in   1       1 = inverse transform
//  in_data      in   DATA_W  signed sample
//  in_valid     in   1       sample present
//  in_ready     out  1       sample accepted when in_valid & in_ready
//  sink_ready   in   1       FFT core can accept a beat
//  sink_valid   out  1       beat present on sink_real/imag
//  sink_sop     out  1       first beat of frame
//  sink_eop     out  1       last beat of frame
//  sink_real    out  DATA_W  = accepted in_data
//  sink_imag    out  DATA_W  always 0
//  sink_error   out  2       00 ok, 01 bad cfg_pts, 11 aborted frame
//  inverse      out  1       latched cfg_inverse for current frame
//  fft_pts      out  PTS_W   latched cfg_pts for current frame
//  busy         out  1       state != IDLE
//  frame_done   out  1       one-cycle pulse when eop beat transfers
//  frame_cnt    out  CNT_W   completed frames, wraps to 0
// BEHAVIOUR
//  Reset: all outputs 0 (fft_pts=0, inverse=0); state IDLE; index=0.
//  Transfer = sink_valid & sink_ready. One registered output stage.
//  in_ready = (state==STREAM) & (!sink_valid | sink_ready) & !abort.
//  Latency: sample accepted in cycle N is on sink_* in cycle N+1.
//  Unaccepted beat holds sink_* stable until transfer.
//  States:
//   IDLE:   start & cfg_pts legal -> latch cfg_pts/cfg_inverse, index=0, STREAM.
//           start & cfg_pts illegal -> sink_error=01 one cycle, stay IDLE.
//   STREAM: per accepted sample, sink_sop=(index==0), sink_eop=(index==fft_pts-1),
//           index++. On accept with index==fft_pts-1 -> DRAIN; in_ready low.
//   DRAIN:  wait for eop transfer -> frame_done pulse, frame_cnt++, IDLE.
//  abort in STREAM/DRAIN: sink_valid=0 next cycle, sink_error=11 one cycle,
//   index=0, IDLE; frame_cnt unchanged; abort in IDLE ignored.
//  abort and eop transfer in same cycle: transfer wins, frame counts, no error.
//  start outside IDLE ignored. cfg_* changes mid-frame ignored until next latch.
//  frame_cnt wraps 2^CNT_W-1 -> 0. rst_n low mid-frame: immediate return to reset
//  values, partial frame discarded, no eop emitted.
// CONFIGURATION
//  FFT_CONT_MODE_EN defined: on eop transfer, if start is still high and cfg_pts
//   legal, re-latch cfg and go straight to STREAM; first sample of next frame may
//   be accepted the cycle after eop transfer (no IDLE gap).
//  Not defined: always returns to IDLE; at least one idle cycle between frames.
// TESTING
//  cfg_pts=64, start pulse, in_valid=1, sink_ready=1 -> sop on beat 0, eop on
//   beat 63, frame_done one cycle after eop, frame_cnt=1, sink_imag=0 throughout.
//  cfg_pts=256, sink_ready toggling 1/0 each cycle -> 256 beats in order, no
//   drop/duplicate, sink_* stable while stalled.
//  cfg_pts=100, start -> sink_error=01 one cycle, busy=0, no sink_valid.
//  cfg_pts=1024, abort at beat 500 -> sink_error=11, sink_valid=0, busy=0,
//   frame_cnt unchanged; next start gives full 1024-beat frame with sop.
//  cfg_inverse=1 latched, cfg_inverse=0 mid-frame -> inverse stays 1 to eop.
//  FFT_CONT_MODE_EN, start held, cfg_pts=64 -> 3 back-to-back frames,
//   sop immediately after eop, frame_cnt=3.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frames a real-valued sample stream into FFT-core sink packets (sop/eop/valid, backpressure).
// Optional FFT_CONT_MODE_EN: back-to-back frames with no idle gap while start stays high.
module fft_frame_sequencer #(
    parameter int DATA_W = 14,
    parameter int PTS_W  = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PTS_W-1:0]  cfg_pts,
    input  logic              cfg_inverse,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic [1:0]        sink_error,
    output logic              inverse,
    output logic [PTS_W-1:0]  fft_pts,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt
);

    // state    | meaning
    // S_IDLE   | waiting for start with a legal cfg_pts
    // S_STREAM | accepting samples until the last one of the frame
    // S_DRAIN  | last beat registered, waiting for the sink to take it
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTS_W-1:0] index_q;
    logic             cfg_legal;
    logic             xfer;
    logic             eop_xfer;
    logic             accept;
    logic             is_last;
    logic             latch_cfg;
    logic             frame_end;
    logic             abort_hit;
    logic [1:0]       err_d;

    assign cfg_legal = (cfg_pts == PTS_W'(64))  || (cfg_pts == PTS_W'(128)) ||
                       (cfg_pts == PTS_W'(256)) || (cfg_pts == PTS_W'(512)) ||
                       (cfg_pts == PTS_W'(1024));

    assign xfer      = sink_valid & sink_ready;
    assign eop_xfer  = xfer & sink_eop;
    assign in_ready  = (state_q == S_STREAM) & (!sink_valid | sink_ready) & !abort;
    assign accept    = in_valid & in_ready;
    assign is_last   = (index_q == fft_pts - PTS_W'(1));
    assign busy      = (state_q != S_IDLE);
    assign sink_imag = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        frame_end = 1'b0;
        abort_hit = 1'b0;
        err_d     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        latch_cfg = 1'b1;
                        state_d   = S_STREAM;
                    end else begin
                        err_d = 2'b01;
                    end
                end
            end
            S_STREAM: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    err_d     = 2'b11;
                    state_d   = S_IDLE;
                end else if (accept && is_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A completing eop transfer takes priority over a simultaneous abort.
                if (eop_xfer) begin
                    frame_end = 1'b1;
                    state_d   = S_IDLE;
`ifdef FFT_CONT_MODE_EN
                    if (start && cfg_legal) begin
                        latch_cfg = 1'b1;
                        state_d   = S_STREAM;
                    end
`endif
                end else if (abort) begin
                    abort_hit = 1'b1;
                    err_d     = 2'b11;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q    <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            sink_error <= 2'b00;
            inverse    <= 1'b0;
            fft_pts    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            sink_error <= err_d;
            frame_done <= frame_end;

            if (frame_end) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (latch_cfg) begin
                fft_pts <= cfg_pts;
                inverse <= cfg_inverse;
            end

            if (latch_cfg || abort_hit) begin
                index_q <= '0;
            end else if (accept) begin
                index_q <= is_last ? '0 : index_q + PTS_W'(1);
            end

            // Single output register: load on accept, hold while stalled, clear once taken.
            if (abort_hit) begin
                sink_valid <= 1'b0;
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
            end else if (accept) begin
                sink_valid <= 1'b1;
                sink_real  <= in_data;
                sink_sop   <= (index_q == '0);
                sink_eop   <= is_last;
            end else if (xfer) begin
                sink_valid <= 1'b0;
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer against a sample-count based frame model.
// Build with FFT_CONT_MODE_EN defined to also exercise back-to-back frames.
module tb_fft_frame_sequencer;
    localparam int DATA_W = 14;
    localparam int PTS_W  = 11;
    localparam int CNT_W  = 3;   // small counter so the wrap is reachable
`ifdef FFT_CONT_MODE_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PTS_W-1:0]  cfg_pts = '0;
    logic              cfg_inverse = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sink_ready = 1'b1;
    logic              sink_valid, sink_sop, sink_eop;
    logic [DATA_W-1:0] sink_real, sink_imag;
    logic [1:0]        sink_error;
    logic              inverse;
    logic [PTS_W-1:0]  fft_pts;
    logic              busy, frame_done;
    logic [CNT_W-1:0]  frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int beats;

    always #5 clk = ~clk;

    fft_frame_sequencer #(.DATA_W(DATA_W), .PTS_W(PTS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_pts(cfg_pts), .cfg_inverse(cfg_inverse),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_error(sink_error), .inverse(inverse), .fft_pts(fft_pts),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int p);
        return (p == 64) || (p == 128) || (p == 256) || (p == 512) || (p == 1024);
    endfunction

    // Model: a frame is "open" with m_acc samples taken out of m_pts; one pending output beat.
    bit                m_busy, m_valid, m_sop, m_eop, m_inv, m_done;
    int                m_acc, m_pts, m_frames;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_err;

    always @(negedge clk) begin : compare
        bit exp_rdy, xf, acc;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_sop = 0; m_eop = 0; m_inv = 0; m_done = 0;
            m_acc = 0; m_pts = 0; m_frames = 0; m_data = '0; m_err = 2'b00;
        end
        exp_rdy = m_busy && (m_acc < m_pts) && (!m_valid || sink_ready) && !abort;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("sink_valid", int'(sink_valid), int'(m_valid));
        if (m_valid) begin
            chk("sink_real", int'(sink_real), int'(m_data));
            chk("sink_sop", int'(sink_sop), int'(m_sop));
            chk("sink_eop", int'(sink_eop), int'(m_eop));
        end
        chk("sink_imag", int'(sink_imag), 0);
        chk("sink_error", int'(sink_error), int'(m_err));
        chk("busy", int'(busy), int'(m_busy));
        chk("fft_pts", int'(fft_pts), m_pts);
        chk("inverse", int'(inverse), int'(m_inv));
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("frame_cnt", int'(frame_cnt), m_frames);

        if (rst_n) begin
            xf  = m_valid && sink_ready;
            acc = in_valid && exp_rdy;
            m_err  = 2'b00;
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    if (legal(int'(cfg_pts))) begin
                        m_busy = 1; m_pts = int'(cfg_pts); m_inv = cfg_inverse; m_acc = 0;
                    end else begin
                        m_err = 2'b01;
                    end
                end
            end else if (xf && m_eop) begin
                m_done   = 1;
                m_frames = (m_frames + 1) % (1 << CNT_W);
                m_valid  = 0;
                m_busy   = 0;
                if (CONT && start && legal(int'(cfg_pts))) begin
                    m_busy = 1; m_pts = int'(cfg_pts); m_inv = cfg_inverse; m_acc = 0;
                end
            end else if (abort) begin
                m_valid = 0;
                m_err   = 2'b11;
                m_busy  = 0;
            end else begin
                if (xf) m_valid = 0;
                if (acc) begin
                    m_valid = 1;
                    m_data  = in_data;
                    m_sop   = (m_acc == 0);
                    m_eop   = (m_acc == m_pts - 1);
                    m_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_traffic(input int mode, input int cyc);
        in_data = DATA_W'($urandom);
        case (mode)
            0: begin in_valid = 1'b1; sink_ready = 1'b1; end
            1: begin in_valid = 1'b1; sink_ready = cyc[0]; end
            default: begin
                in_valid   = ($urandom_range(0, 3) != 0);
                sink_ready = ($urandom_range(0, 3) != 0);
            end
        endcase
    endtask

    task automatic run_frame(input int pts, input bit inv, input int mode,
                             input bit flip_cfg, input int abort_rate);
        bit done;
        done  = 0;
        beats = 0;
        cfg_pts = PTS_W'(pts);
        cfg_inverse = inv;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (flip_cfg) begin
            cfg_inverse = !inv;
            cfg_pts     = PTS_W'(64);
        end
        for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
            set_traffic(mode, cyc);
            abort = (abort_rate != 0) && ($urandom_range(1, abort_rate) == 1);
            if (sink_valid && sink_ready) beats++;
            tick();
            if (frame_done || !busy) done = 1;
        end
        abort = 1'b0;
        in_valid = 1'b0;
        sink_ready = 1'b1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got no completion expected completion for pts=%0d", pts);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(frame_cnt), 0);
        chk("rst_pts", int'(fft_pts), 0);
        chk("rst_valid", int'(sink_valid), 0);
        rst_n = 1'b1;
        tick();

        // 64-point frame, free-flowing
        run_frame(64, 1'b0, 0, 1'b0, 0);
        chk("beats_64", beats, 64);
        chk("done_pulse", int'(frame_done), 1);
        chk("cnt_1", int'(frame_cnt), 1);
        tick();
        chk("done_one_cycle", int'(frame_done), 0);

        // 256 points with sink_ready toggling
        run_frame(256, 1'b0, 1, 1'b0, 0);
        chk("beats_256", beats, 256);
        chk("cnt_2", int'(frame_cnt), 2);
        tick();

        // illegal length
        cfg_pts = PTS_W'(100);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_cfg_err", int'(sink_error), 1);
        chk("bad_cfg_busy", int'(busy), 0);
        tick();
        chk("bad_cfg_err_clear", int'(sink_error), 0);
        chk("bad_cfg_valid", int'(sink_valid), 0);

        // 1024 points aborted around beat 500, then a full 1024 frame
        cfg_pts = PTS_W'(1024);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        sink_ready = 1'b1;
        repeat (500) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_err", int'(sink_error), 3);
        chk("abort_valid", int'(sink_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(frame_cnt), 2);
        tick();
        run_frame(1024, 1'b0, 0, 1'b0, 0);
        chk("beats_1024", beats, 1024);
        chk("cnt_3", int'(frame_cnt), 3);
        tick();

        // inverse latched, cfg changed mid-frame
        run_frame(128, 1'b1, 2, 1'b1, 0);
        chk("beats_128", beats, 128);
        chk("inv_latched", int'(inverse), 1);
        chk("pts_latched", int'(fft_pts), 128);
        chk("cnt_4", int'(frame_cnt), 4);
        tick();

        // abort raised in the same cycle as the eop transfer
        cfg_pts = PTS_W'(64);
        cfg_inverse = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            set_traffic(0, cyc);
            abort = sink_valid && sink_eop;
            tick();
            if (frame_done || !busy) break;
        end
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_eop_done", int'(frame_done), 1);
        chk("abort_eop_err", int'(sink_error), 0);
        chk("cnt_5", int'(frame_cnt), 5);
        tick();

        // reset mid-frame
        cfg_pts = PTS_W'(64);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(sink_valid), 0);
        chk("midrst_cnt", int'(frame_cnt), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // random legal frames; 10 completions wrap the 3-bit counter to 2
        for (int f = 0; f < 10; f++) begin
            run_frame(64 << $urandom_range(0, 4), 1'($urandom), 2, 1'b0, 0);
            tick();
        end
        chk("cnt_wrap", int'(frame_cnt), 2);

        // random frames with occasional aborts, model-checked only
        for (int f = 0; f < 6; f++) begin
            run_frame(64 << $urandom_range(0, 2), 1'($urandom), 2, 1'b0, 150);
            tick();
        end

`ifdef FFT_CONT_MODE_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        begin
            int dones;
            dones = 0;
            cfg_pts = PTS_W'(64);
            start = 1'b1;
            for (int cyc = 0; cyc < 1000 && dones < 3; cyc++) begin
                set_traffic(0, cyc);
                tick();
                if (frame_done) begin
                    dones++;
                    if (dones == 2) start = 1'b0;
                end
            end
            start = 1'b0;
            in_valid = 1'b0;
            chk("cont_dones", dones, 3);
            chk("cont_cnt", int'(frame_cnt), 3);
            chk("cont_idle", int'(busy), 0);
        end
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
